// File: rtl/cmp_load_sequencer.sv
// rtl/cmp_load_sequencer.sv - button-driven operand entry and result capture for the 8-bit comparator
module cmp_load_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic [3:0] Y,
  input  logic       cmp_le,
  input  logic       cmp_eq,
  input  logic       cmp_gr,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       cmp_start,
  output logic       le,
  output logic       eq,
  output logic       gr,
  output logic       result_valid,
  output logic       seq_err,
  output logic [2:0] state
);

  // Counter must be able to hold DEBOUNCE_CYCLES-1; sized one bit generous.
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    W_AL = 3'd0,
    W_AH = 3'd1,
    W_BL = 3'd2,
    W_BH = 3'd3,
    CMP  = 3'd4,
    CAP  = 3'd5,
    RES  = 3'd6
  } state_t;

  // Buttons packed as bit0=PB1 .. bit3=PB4 so every stage can loop over them.
  logic [3:0] pb_raw;
  assign pb_raw = {PB4, PB3, PB2, PB1};

  logic [3:0]    pb_meta_q;
  logic [3:0]    pb_sync_q;
  logic [3:0]    y_meta_q;
  logic [3:0]    y_sync_q;
  logic [3:0]    db_level_q;
  logic [3:0]    db_prev_q;
  logic [3:0]    press_q;
  logic [CW-1:0] db_cnt_q [4];

  state_t     state_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       cmp_start_q;
  logic       le_q;
  logic       eq_q;
  logic       gr_q;
  logic       valid_q;
  logic       seq_err_q;

  logic [3:0] expect_mask;
  logic       press_ok;
  logic       press_bad;

  // Two-flop synchronizers for the raw buttons and the switch nibble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_meta_q <= 4'b0000;
      pb_sync_q <= 4'b0000;
      y_meta_q  <= 4'b0000;
      y_sync_q  <= 4'b0000;
    end else begin
      pb_meta_q <= pb_raw;
      pb_sync_q <= pb_meta_q;
      y_meta_q  <= Y;
      y_sync_q  <= y_meta_q;
    end
  end

  // Per-button debounce: level flips after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_level_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pb_sync_q[i] == db_level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_LAST) begin
          db_level_q[i] <= ~db_level_q[i];
          db_cnt_q[i]   <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Press events: registered one-cycle pulse on a rising debounced level; releases ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_prev_q <= 4'b0000;
      press_q   <= 4'b0000;
    end else begin
      db_prev_q <= db_level_q;
      press_q   <= db_level_q & ~db_prev_q;
    end
  end

  // Which single button the current state accepts; none while comparing or capturing.
  always_comb begin
    expect_mask = 4'b0000;
    press_ok    = 1'b0;
    press_bad   = 1'b0;
    case (state_q)
      W_AL, RES: expect_mask = 4'b0001;
      W_AH:      expect_mask = 4'b0010;
      W_BL:      expect_mask = 4'b0100;
      W_BH:      expect_mask = 4'b1000;
      default:   expect_mask = 4'b0000;
    endcase
    // A correct press coinciding with any other press is still an error.
    if (expect_mask != 4'b0000) begin
      press_ok  = (press_q == expect_mask);
      press_bad = (press_q != 4'b0000) && (press_q != expect_mask);
    end
  end

  // Entry-order FSM with registered operand, strobe and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= W_AL;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      cmp_start_q <= 1'b0;
      le_q        <= 1'b0;
      eq_q        <= 1'b0;
      gr_q        <= 1'b0;
      valid_q     <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      cmp_start_q <= 1'b0;
      if (press_ok) begin
        seq_err_q <= 1'b0;
      end else if (press_bad) begin
        seq_err_q <= 1'b1;
      end
      case (state_q)
        W_AL: begin
          if (press_ok) begin
            a_q[3:0] <= y_sync_q;
            state_q  <= W_AH;
          end
        end
        W_AH: begin
          if (press_ok) begin
            a_q[7:4] <= y_sync_q;
            state_q  <= W_BL;
          end
        end
        W_BL: begin
          if (press_ok) begin
            b_q[3:0] <= y_sync_q;
            state_q  <= W_BH;
          end
        end
        W_BH: begin
          if (press_ok) begin
            b_q[7:4]    <= y_sync_q;
            cmp_start_q <= 1'b1;
            state_q     <= CMP;
          end
        end
        CMP: begin
          // Operands are frozen here; the comparator settles during this cycle.
          state_q <= CAP;
        end
        CAP: begin
          le_q    <= cmp_le;
          eq_q    <= cmp_eq;
          gr_q    <= cmp_gr;
          valid_q <= 1'b1;
          state_q <= RES;
        end
        RES: begin
          // New round: B is kept until the operator reloads it.
          if (press_ok) begin
            a_q[3:0] <= y_sync_q;
            valid_q  <= 1'b0;
            state_q  <= W_AH;
          end
        end
        default: begin
          state_q <= W_AL;
        end
      endcase
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign cmp_start    = cmp_start_q;
  assign le           = le_q;
  assign eq           = eq_q;
  assign gr           = gr_q;
  assign result_valid = valid_q;
  assign seq_err      = seq_err_q;
  assign state        = state_q;

endmodule
